// File: rtl/mem_access_unit.sv
// mem_access_unit
// ---------------
// Data-side load/store unit. Takes one decoded memory command (one-hot size
// strobes for store/load plus sign-extension select), checks it for
// alignment, and runs it as a single word-aligned req/ack bus transfer.
// Load data is lane-extracted and extended on the ack. A bounded wait
// counter aborts a transfer that is never acknowledged.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   start                      command valid (only looked at in IDLE)
//   write_mem_1B/2B/4B         store size strobes
//   read_mem_1B/2B/4B          load size strobes
//   extension_mem              1 = sign-extend loads, 0 = zero-extend
//   addr, wdata                byte address, store data
//   busy, done                 in-flight flag, one-cycle completion pulse
//   rdata                      load result, held until the next load completes
//   misaligned, bus_err        fault flags, valid together with done
//   mem_req, mem_we, mem_addr,
//   mem_wstrb, mem_wdata       bus request side (all registered)
//   mem_ack, mem_rdata         bus response side
module mem_access_unit #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        write_mem_1B,
    input  logic        write_mem_2B,
    input  logic        write_mem_4B,
    input  logic        read_mem_1B,
    input  logic        read_mem_2B,
    input  logic        read_mem_4B,
    input  logic        extension_mem,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] rdata,
    output logic        misaligned,
    output logic        bus_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    // access size encoding kept with the latched command
    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    // number of size strobes raised; more than one is a decoder fault
    function automatic logic [2:0] count_strobes(input logic [5:0] s);
        logic [2:0] n;
        n = 3'd0;
        for (int i = 0; i < 6; i++) begin
            n = n + {2'b00, s[i]};
        end
        return n;
    endfunction

    // byte-lane enables for a store of the given size at the given offset
    function automatic logic [3:0] lane_strobe(input logic [1:0] size, input logic [1:0] off);
        logic [3:0] m;
        case (size)
            SZ_B:    m = 4'b0001 << off;
            SZ_H:    m = off[1] ? 4'b1100 : 4'b0011;
            SZ_W:    m = 4'b1111;
            default: m = 4'b0000;
        endcase
        return m;
    endfunction

    // store data replicated across every lane it could land in
    function automatic logic [31:0] replicate(input logic [1:0] size, input logic [31:0] d);
        logic [31:0] r;
        case (size)
            SZ_B:    r = {4{d[7:0]}};
            SZ_H:    r = {2{d[15:0]}};
            SZ_W:    r = d;
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    // pick the addressed byte/half out of the bus word and extend it
    function automatic logic [31:0] extract_load(input logic [1:0] size, input logic ext,
                                                 input logic [1:0] off, input logic [31:0] word);
        logic [31:0] sh;
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        sh = word >> {off, 3'b000};
        b  = sh[7:0];
        h  = off[1] ? word[31:16] : word[15:0];
        case (size)
            SZ_B:    r = {{24{ext & b[7]}}, b};
            SZ_H:    r = {{16{ext & h[15]}}, h};
            SZ_W:    r = word;
            default: r = word;
        endcase
        return r;
    endfunction

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [1:0]  size_q, size_d;
    logic [1:0]  off_q, off_d;
    logic        ext_q, ext_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        mis_q, mis_d;
    logic        berr_q, berr_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [31:0] maddr_q, maddr_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic [31:0] mwdata_q, mwdata_d;
    logic [31:0] rdata_q, rdata_d;

    logic [5:0]  strb_s;
    logic [2:0]  n_strb_s;
    logic        cmd_we_s;
    logic [1:0]  cmd_size_s;
    logic        cmd_fault_s;

    // classify the incoming command: size, direction and alignment fault
    always_comb begin
        strb_s     = {read_mem_4B, read_mem_2B, read_mem_1B,
                      write_mem_4B, write_mem_2B, write_mem_1B};
        n_strb_s   = count_strobes(strb_s);
        cmd_we_s   = write_mem_1B | write_mem_2B | write_mem_4B;
        if (write_mem_1B | read_mem_1B) begin
            cmd_size_s = SZ_B;
        end else if (write_mem_2B | read_mem_2B) begin
            cmd_size_s = SZ_H;
        end else begin
            cmd_size_s = SZ_W;
        end
        cmd_fault_s = (n_strb_s > 3'd1)
                    | ((write_mem_2B | read_mem_2B) & addr[0])
                    | ((write_mem_4B | read_mem_4B) & (addr[1:0] != 2'b00));
    end

    // next-state and next-output logic for the IDLE/REQ/DONE sequencer
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        size_d   = size_q;
        off_d    = off_q;
        ext_d    = ext_q;
        mis_d    = mis_q;
        berr_d   = berr_q;
        req_d    = req_q;
        we_d     = we_q;
        maddr_d  = maddr_q;
        wstrb_d  = wstrb_q;
        mwdata_d = mwdata_q;
        rdata_d  = rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (cmd_fault_s) begin
                        state_d = ST_DONE;
                        mis_d   = 1'b1;
                        berr_d  = 1'b0;
                    end else if (n_strb_s == 3'd0) begin
                        // empty command: complete without touching the bus
                        state_d = ST_DONE;
                        mis_d   = 1'b0;
                        berr_d  = 1'b0;
                    end else begin
                        state_d  = ST_REQ;
                        req_d    = 1'b1;
                        cnt_d    = 8'd0;
                        mis_d    = 1'b0;
                        berr_d   = 1'b0;
                        size_d   = cmd_size_s;
                        off_d    = addr[1:0];
                        ext_d    = extension_mem;
                        we_d     = cmd_we_s;
                        maddr_d  = {addr[31:2], 2'b00};
                        wstrb_d  = cmd_we_s ? lane_strobe(cmd_size_s, addr[1:0]) : 4'b0000;
                        mwdata_d = cmd_we_s ? replicate(cmd_size_s, wdata) : 32'd0;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQ: begin
                // ack is checked first so an ack on the last allowed cycle wins
                if (mem_ack) begin
                    state_d = ST_DONE;
                    req_d   = 1'b0;
                    berr_d  = 1'b0;
                    if (!we_q) begin
                        rdata_d = extract_load(size_q, ext_q, off_q, mem_rdata);
                    end else begin
                        rdata_d = rdata_q;
                    end
                end else if ((cnt_q + 8'd1) == TIMEOUT_C) begin
                    state_d = ST_DONE;
                    req_d   = 1'b0;
                    berr_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                mis_d   = 1'b0;
                berr_d  = 1'b0;
                cnt_d   = 8'd0;
            end
            default: begin
                state_d = ST_IDLE;
                req_d   = 1'b0;
                mis_d   = 1'b0;
                berr_d  = 1'b0;
                cnt_d   = 8'd0;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    // state and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 8'd0;
            size_q   <= SZ_B;
            off_q    <= 2'b00;
            ext_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            mis_q    <= 1'b0;
            berr_q   <= 1'b0;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            maddr_q  <= 32'd0;
            wstrb_q  <= 4'b0000;
            mwdata_q <= 32'd0;
            rdata_q  <= 32'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            size_q   <= size_d;
            off_q    <= off_d;
            ext_q    <= ext_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            mis_q    <= mis_d;
            berr_q   <= berr_d;
            req_q    <= req_d;
            we_q     <= we_d;
            maddr_q  <= maddr_d;
            wstrb_q  <= wstrb_d;
            mwdata_q <= mwdata_d;
            rdata_q  <= rdata_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign rdata      = rdata_q;
    assign misaligned = mis_q;
    assign bus_err    = berr_q;
    assign mem_req    = req_q;
    assign mem_we     = we_q;
    assign mem_addr   = maddr_q;
    assign mem_wstrb  = wstrb_q;
    assign mem_wdata  = mwdata_q;

endmodule
